mul_div: RTL and testbench

- Multi-cycle multiply/divide unit for the S1C88 core; the sequential counterpart to the combinational ALU.
- Executes MLT (HL = L * A) and DIV (HL / A: L = quotient, H = remainder) using iterative shift-add and restoring-subtract.
- Sits beside the ALU in the execute stage. The control FSM issues start, stalls on busy, and writes back result and flags when done pulses.
- Flag vector uses the ALU ordering: bit0 Z, bit1 C, bit2 V, bit3 S.

---
 rtl/mul_div.sv | 157 +++++++++++++++
 tb/tb_mul_div.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/mul_div.sv
// Iterative 8x8 multiply / 16-by-8 restoring divide unit, working beside the ALU.
// It processes BITS_PER_CYCLE multiplier or quotient bits per RUN cycle.
module mul_div #(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        op,
  input  logic [15:0] hl_in,
  input  logic [7:0]  a_in,
  output logic        busy,
  output logic        done,
  output logic [15:0] result,
  output logic [3:0]  flags,
  output logic        div_zero
);

  localparam int N_ITER = 8 / BITS_PER_CYCLE;
  localparam logic [3:0] LAST_CNT = 4'(N_ITER - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state;
  logic        op_q;
  logic [3:0]  cnt;
  logic [15:0] acc_q;
  logic [15:0] mcand_q;
  logic [7:0]  shf_q;
  logic [7:0]  rem_q;
  logic [7:0]  dvsr_q;

  logic [15:0] acc_n;
  logic [15:0] mcand_n;
  logic [7:0]  shf_n;
  logic [7:0]  rem_n;

  // One shift-add step: accumulate the multiplicand when the multiplier LSB is set.
  function automatic logic [39:0] mul_step(input logic [15:0] acc,
                                           input logic [15:0] mc,
                                           input logic [7:0]  mp);
    logic [15:0] sum;
    sum = mp[0] ? acc + mc : acc;
    return {sum, mc[14:0], 1'b0, 1'b0, mp[7:1]};
  endfunction

  // One restoring step; the 9-bit partial remainder keeps the bit shifted out.
  function automatic logic [15:0] div_step(input logic [7:0] rem,
                                           input logic [7:0] quo,
                                           input logic [7:0] dvsr);
    logic [8:0] pr;
    logic [7:0] qn;
    pr = {rem, quo[7]};
    qn = {quo[6:0], 1'b0};
    if (pr >= {1'b0, dvsr}) begin
      pr    = pr - {1'b0, dvsr};
      qn[0] = 1'b1;
    end
    return {pr[7:0], qn};
  endfunction

  // Flag vector in ALU order {S, V, C, Z}; V and C are never set on a completed op.
  function automatic logic [3:0] done_flags(input logic zero, input logic sign);
    return {sign, 1'b0, 1'b0, zero};
  endfunction

  always_comb begin
    acc_n   = acc_q;
    mcand_n = mcand_q;
    shf_n   = shf_q;
    rem_n   = rem_q;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (op_q) begin
        {rem_n, shf_n} = div_step(rem_n, shf_n, dvsr_q);
      end else begin
        {acc_n, mcand_n, shf_n} = mul_step(acc_n, mcand_n, shf_n);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= 16'h0000;
      flags    <= 4'h0;
      div_zero <= 1'b0;
      op_q     <= 1'b0;
      cnt      <= 4'h0;
      acc_q    <= 16'h0000;
      mcand_q  <= 16'h0000;
      shf_q    <= 8'h00;
      rem_q    <= 8'h00;
      dvsr_q   <= 8'h00;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_q     <= op;
            cnt      <= 4'h0;
            flags    <= 4'h0;
            div_zero <= 1'b0;
            acc_q    <= 16'h0000;
            mcand_q  <= {8'h00, hl_in[7:0]};
            shf_q    <= op ? hl_in[7:0] : a_in;
            rem_q    <= hl_in[15:8];
            dvsr_q   <= a_in;
            busy     <= 1'b1;
            if (op && a_in == 8'h00) begin
              div_zero <= 1'b1;
              result   <= hl_in;
              done     <= 1'b1;
              state    <= DONE;
            end else if (op && hl_in[15:8] >= a_in) begin
              // Quotient would not fit in 8 bits: leave HL untouched and flag V.
              result   <= hl_in;
              flags    <= 4'b0100;
              done     <= 1'b1;
              state    <= DONE;
            end else begin
              state    <= RUN;
            end
          end
        end
        RUN: begin
          acc_q   <= acc_n;
          mcand_q <= mcand_n;
          shf_q   <= shf_n;
          rem_q   <= rem_n;
          cnt     <= cnt + 4'h1;
          if (cnt == LAST_CNT) begin
            if (op_q) begin
              result <= {rem_n, shf_n};
              flags  <= done_flags(shf_n == 8'h00, shf_n[7]);
            end else begin
              result <= acc_n;
              flags  <= done_flags(acc_n == 16'h0000, acc_n[15]);
            end
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div.sv
// Directed bench for mul_div: three instances (1, 2 and 4 bits per cycle) share stimulus
// and are checked against hand-computed results, flags and cycle timing.
module tb_mul_div;

  logic        clk;
  logic        reset;
  logic        start;
  logic        op;
  logic [15:0] hl_in;
  logic [7:0]  a_in;

  logic [2:0]  busy_w;
  logic [2:0]  done_w;
  logic [15:0] res_w [3];
  logic [3:0]  flg_w [3];
  logic [2:0]  dz_w;

  int passed = 0;
  int total  = 0;
  int bpc [3] = '{1, 2, 4};

  mul_div #(.BITS_PER_CYCLE(1)) u_bpc1 (
    .clk(clk), .reset(reset), .start(start), .op(op), .hl_in(hl_in), .a_in(a_in),
    .busy(busy_w[0]), .done(done_w[0]), .result(res_w[0]), .flags(flg_w[0]), .div_zero(dz_w[0])
  );
  mul_div #(.BITS_PER_CYCLE(2)) u_bpc2 (
    .clk(clk), .reset(reset), .start(start), .op(op), .hl_in(hl_in), .a_in(a_in),
    .busy(busy_w[1]), .done(done_w[1]), .result(res_w[1]), .flags(flg_w[1]), .div_zero(dz_w[1])
  );
  mul_div #(.BITS_PER_CYCLE(4)) u_bpc4 (
    .clk(clk), .reset(reset), .start(start), .op(op), .hl_in(hl_in), .a_in(a_in),
    .busy(busy_w[2]), .done(done_w[2]), .result(res_w[2]), .flags(flg_w[2]), .div_zero(dz_w[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one operation (start high for one cycle T), scramble the inputs afterwards,
  // and watch 14 cycles of every instance. Optionally re-assert start mid-operation.
  task automatic run_case(input string name, input logic o, input logic [15:0] hl,
                          input logic [7:0] a, input logic [15:0] er, input logic [3:0] ef,
                          input logic edz, input logic early, input logic glitch);
    int          dc [3];
    logic [15:0] rc [3];
    logic [3:0]  fc [3];
    logic [2:0]  dzc;
    logic [15:0] bm [3];
    int          lat;
    for (int i = 0; i < 3; i++) begin
      dc[i] = 0; rc[i] = 16'h0; fc[i] = 4'h0; bm[i] = 16'h0;
    end
    dzc = 3'b000;
    @(negedge clk);
    start = 1'b1; op = o; hl_in = hl; a_in = a;
    @(posedge clk); #1;
    start = 1'b0; op = ~o; hl_in = 16'hA5A5; a_in = 8'h5A;
    for (int k = 1; k <= 14; k++) begin
      for (int i = 0; i < 3; i++) begin
        if (busy_w[i]) bm[i][k] = 1'b1;
        if (done_w[i]) begin
          if (dc[i] == 0) begin
            dc[i] = k; rc[i] = res_w[i]; fc[i] = flg_w[i]; dzc[i] = dz_w[i];
          end else begin
            dc[i] = 99;
          end
        end
      end
      if (glitch && k == 3) begin
        start = 1'b1; op = ~o; hl_in = 16'h1234; a_in = 8'h11;
      end
      if (glitch && k == 4) start = 1'b0;
      @(posedge clk); #1;
    end
    for (int i = 0; i < 3; i++) begin
      lat = early ? 1 : (8 / bpc[i]) + 1;
      check($sformatf("%s bpc%0d done_cycle", name, bpc[i]), 32'(dc[i]), 32'(lat));
      check($sformatf("%s bpc%0d result", name, bpc[i]), 32'(rc[i]), 32'(er));
      check($sformatf("%s bpc%0d flags", name, bpc[i]), 32'(fc[i]), 32'(ef));
      check($sformatf("%s bpc%0d div_zero", name, bpc[i]), 32'(dzc[i]), 32'(edz));
      check($sformatf("%s bpc%0d busy_cycles", name, bpc[i]), 32'(bm[i]),
            32'((16'h1 << (lat + 1)) - 16'h2));
    end
  endtask

  int done_cnt [3];

  initial begin
    reset = 1'b0; start = 1'b0; op = 1'b0; hl_in = 16'h0000; a_in = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++)
      check($sformatf("reset bpc%0d outputs", bpc[i]),
            {7'h0, busy_w[i], done_w[i], dz_w[i], flg_w[i], res_w[i]}, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;

    run_case("mlt_0c_0a", 1'b0, 16'h000C, 8'h0A, 16'h0078, 4'h0, 1'b0, 1'b0, 1'b0);
    run_case("mlt_ff_ff", 1'b0, 16'h77FF, 8'hFF, 16'hFE01, 4'b1000, 1'b0, 1'b0, 1'b0);
    run_case("mlt_00_55", 1'b0, 16'h0000, 8'h55, 16'h0000, 4'b0001, 1'b0, 1'b0, 1'b0);
    run_case("div_0100_03", 1'b1, 16'h0100, 8'h03, 16'h0155, 4'h0, 1'b0, 1'b0, 1'b0);
    run_case("div_0007_09", 1'b1, 16'h0007, 8'h09, 16'h0700, 4'b0001, 1'b0, 1'b0, 1'b0);
    run_case("div_04ff_05", 1'b1, 16'h04FF, 8'h05, 16'h04FF, 4'b1000, 1'b0, 1'b0, 1'b0);
    run_case("div_ovf_0300_02", 1'b1, 16'h0300, 8'h02, 16'h0300, 4'b0100, 1'b0, 1'b1, 1'b0);
    run_case("div_ovf_eq_0500_05", 1'b1, 16'h0500, 8'h05, 16'h0500, 4'b0100, 1'b0, 1'b1, 1'b0);
    run_case("div_zero", 1'b1, 16'h1234, 8'h00, 16'h1234, 4'h0, 1'b1, 1'b1, 1'b0);
    run_case("mlt_start_in_run", 1'b0, 16'h0013, 8'h07, 16'h0085, 4'h0, 1'b0, 1'b0, 1'b1);

    // Abort a multiply with reset sampled at the end of cycle T+4.
    for (int i = 0; i < 3; i++) done_cnt[i] = 0;
    @(negedge clk);
    start = 1'b1; op = 1'b0; hl_in = 16'h00FF; a_in = 8'hFF;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      for (int i = 0; i < 3; i++) if (done_w[i]) done_cnt[i]++;
      if (k == 4) reset = 1'b0;
      if (k == 5) begin
        for (int i = 0; i < 3; i++)
          check($sformatf("abort bpc%0d outputs", bpc[i]),
                {7'h0, busy_w[i], done_w[i], dz_w[i], flg_w[i], res_w[i]}, 32'h0);
        reset = 1'b1;
      end
      @(posedge clk); #1;
    end
    check("abort bpc1 done_pulses", 32'(done_cnt[0]), 32'd0);
    check("abort bpc2 done_pulses", 32'(done_cnt[1]), 32'd0);
    check("abort bpc4 done_pulses", 32'(done_cnt[2]), 32'd1);

    run_case("after_abort_div", 1'b1, 16'h0100, 8'h03, 16'h0155, 4'h0, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
